// File: rtl/w0rm_core_pkg.sv
// Shared definitions for the W0RM core: address-width derivation and
// helpers for slicing flattened multi-port buses.
package w0rm_core_pkg;

    // Ceiling log2 of a count.
    function automatic int w0rm_log2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

    // Register address width, never narrower than one bit.
    function automatic int reg_addr_bits(input int num_registers);
        int bits;
        bits = w0rm_log2(num_registers);
        return (bits < 1) ? 1 : bits;
    endfunction

    // Low bit of port 'port' inside a flattened bus of 'width'-bit lanes.
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

    localparam int DEFAULT_NUM_REGISTERS = 16;
    localparam int REG_ADDR_BITS         = reg_addr_bits(DEFAULT_NUM_REGISTERS);
    localparam int MAX_READ_PORTS        = 4;
    localparam int MAX_WRITE_PORTS       = 4;

endpackage

// File: rtl/w0rm_core_scoreboard.sv
// Per-register busy bits: set when an issuing instruction reserves its
// destination, cleared by any writeback to that register, wiped by flush.
module w0rm_core_scoreboard
    import w0rm_core_pkg::*;
#(
    parameter int NUM_REGISTERS = 16,
    parameter int NUM_WRITE     = 2,
    parameter int ZERO_REG      = 0,
    localparam int AW           = reg_addr_bits(NUM_REGISTERS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_WRITE-1:0]     wr_en,
    input  logic [NUM_WRITE*AW-1:0]  wr_addr,
    input  logic                     set_en,
    input  logic [AW-1:0]            set_addr,
    output logic [NUM_REGISTERS-1:0] busy_mask
);

    logic [NUM_REGISTERS-1:0] busy_next;

    // Writebacks clear first so a same-cycle reservation of the same register wins.
    always_comb begin
        busy_next = busy_mask;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (wr_en[w]) begin
                busy_next[wr_addr[port_lsb(w, AW) +: AW]] = 1'b0;
            end
        end
        if (set_en) begin
            busy_next[set_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    // Busy register; reset and flush both empty the scoreboard.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            busy_mask <= '0;
        end else begin
            busy_mask <= busy_next;
        end
    end

endmodule

// File: rtl/w0rm_core_regfile_mp.sv
// Multi-ported scoreboarded register file for the register-fetch stage.
// Write-first bypass lets a writeback release a stalled reader in the same
// cycle; operands and the control word are registered toward the ALU.
module w0rm_core_regfile_mp
    import w0rm_core_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 16,
    parameter int NUM_READ      = 2,
    parameter int NUM_WRITE     = 2,
    parameter int USER_WIDTH    = 64,
    parameter int ZERO_REG      = 0,
    localparam int AW           = reg_addr_bits(NUM_REGISTERS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_READ*AW-1:0]          rd_addr,
    input  logic [AW-1:0]                   dest_addr,
    input  logic                            dest_reserve,
    input  logic [NUM_WRITE-1:0]            wr_en,
    input  logic [NUM_WRITE*AW-1:0]         wr_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data,
    input  logic [USER_WIDTH-1:0]           user_in,
    output logic [USER_WIDTH-1:0]           user_out,
    output logic [NUM_REGISTERS-1:0]        busy_mask
);

    logic [DATA_WIDTH-1:0]          regs [NUM_REGISTERS];
    logic [NUM_READ*DATA_WIDTH-1:0] eff_data;
    logic                           hazard;
    logic                           accept;

    // Effective operands with write-first bypass, plus the RAW hazard check.
    always_comb begin
        logic [AW-1:0]         src;
        logic                  hit;
        logic [DATA_WIDTH-1:0] val;
        hazard   = 1'b0;
        eff_data = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            src = rd_addr[port_lsb(k, AW) +: AW];
            val = regs[src];
            hit = 1'b0;
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (wr_en[w] && (wr_addr[port_lsb(w, AW) +: AW] == src)) begin
                    val = wr_data[port_lsb(w, DATA_WIDTH) +: DATA_WIDTH];
                    hit = 1'b1;
                end
            end
            if ((ZERO_REG != 0) && (src == '0)) begin
                val = '0;
            end
            if (busy_mask[src] && !hit) begin
                hazard = 1'b1;
            end
            eff_data[port_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = val;
        end
    end

    assign in_ready = ~hazard & (~out_valid | out_ready) & ~flush & ~reset;
    assign accept   = in_valid & in_ready;

    // Register array; later write ports override earlier ones on the same address.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGISTERS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (wr_en[w] &&
                    !((ZERO_REG != 0) && (wr_addr[port_lsb(w, AW) +: AW] == '0))) begin
                    regs[wr_addr[port_lsb(w, AW) +: AW]] <=
                        wr_data[port_lsb(w, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
        end
    end

    // Output stage toward the ALU; operands deliberately survive a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            rd_data   <= '0;
            user_out  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            user_out  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            rd_data   <= eff_data;
            user_out  <= user_in;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    w0rm_core_scoreboard #(
        .NUM_REGISTERS (NUM_REGISTERS),
        .NUM_WRITE     (NUM_WRITE),
        .ZERO_REG      (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .set_en    (accept & dest_reserve),
        .set_addr  (dest_addr),
        .busy_mask (busy_mask)
    );

endmodule

// File: tb/tb_w0rm_core_regfile_mp.sv
// Bench for the multi-ported register file with ZERO_REG enabled.
// Each vector is one clock cycle; accepted instructions queue their expected
// operands, which are checked while the DUT presents them.
module tb_w0rm_core_regfile_mp;

    localparam int DW  = 32;
    localparam int NR  = 16;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int UW  = 64;
    localparam int AW  = 4;

    typedef struct packed {
        logic        in_valid;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [3:0]  dest;
        logic        reserve;
        logic [1:0]  wen;
        logic [3:0]  wa0;
        logic [31:0] wd0;
        logic [3:0]  wa1;
        logic [31:0] wd1;
        logic [63:0] user;
        logic        out_ready;
        logic        flush;
        logic        exp_in_ready;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
        logic [15:0] exp_busy;
        logic        chk_user_zero;
    } vec_t;

    typedef struct packed {
        logic [63:0] rd;
        logic [63:0] user;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [NRD*AW-1:0] rd_addr;
    logic [AW-1:0]     dest_addr;
    logic              dest_reserve;
    logic [NWR-1:0]    wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic              out_valid;
    logic              out_ready;
    logic [NRD*DW-1:0] rd_data;
    logic [UW-1:0]     user_in;
    logic [UW-1:0]     user_out;
    logic [NR-1:0]     busy_mask;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t exp_q[$];
    vec_t vecs[20];
    vec_t hand[6];

    always #5 clk = ~clk;

    w0rm_core_regfile_mp #(
        .DATA_WIDTH    (DW),
        .NUM_REGISTERS (NR),
        .NUM_READ      (NRD),
        .NUM_WRITE     (NWR),
        .USER_WIDTH    (UW),
        .ZERO_REG      (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rd_addr      (rd_addr),
        .dest_addr    (dest_addr),
        .dest_reserve (dest_reserve),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .rd_data      (rd_data),
        .user_in      (user_in),
        .user_out     (user_out),
        .busy_mask    (busy_mask)
    );

    function automatic vec_t mk(input int iv, input int ra0, input int ra1, input int dest,
                                input int res, input int wen, input int wa0, input int wd0,
                                input int wa1, input int wd1, input logic [63:0] user,
                                input int ordy, input int fl, input int eir, input int er0,
                                input int er1, input int ebusy, input int uz);
        vec_t v;
        v.in_valid      = 1'(iv);
        v.ra0           = 4'(ra0);
        v.ra1           = 4'(ra1);
        v.dest          = 4'(dest);
        v.reserve       = 1'(res);
        v.wen           = 2'(wen);
        v.wa0           = 4'(wa0);
        v.wd0           = 32'(wd0);
        v.wa1           = 4'(wa1);
        v.wd1           = 32'(wd1);
        v.user          = user;
        v.out_ready     = 1'(ordy);
        v.flush         = 1'(fl);
        v.exp_in_ready  = 1'(eir);
        v.exp_rd0       = 32'(er0);
        v.exp_rd1       = 32'(er1);
        v.exp_busy      = 16'(ebusy);
        v.chk_user_zero = 1'(uz);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared = compared + 1;
        if (actual !== expected) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: got %h, wanted %h", name, actual, expected);
        end
    endtask

    // Drive one cycle, check outputs before the edge and the scoreboard after it.
    task automatic applyStimulus(input vec_t v, input logic rst, input string tag);
        exp_t e;
        reset        = rst;
        flush        = v.flush;
        in_valid     = v.in_valid;
        rd_addr      = {v.ra1, v.ra0};
        dest_addr    = v.dest;
        dest_reserve = v.reserve;
        wr_en        = v.wen;
        wr_addr      = {v.wa1, v.wa0};
        wr_data      = {v.wd1, v.wd0};
        user_in      = v.user;
        out_ready    = v.out_ready;
        #2;
        if (exp_q.size() != 0) begin
            checkOutput($sformatf("%s out_valid", tag), 64'(out_valid), 64'd1);
            checkOutput($sformatf("%s rd_data", tag), 64'(rd_data), exp_q[0].rd);
            checkOutput($sformatf("%s user_out", tag), 64'(user_out), exp_q[0].user);
            if (v.out_ready) begin
                void'(exp_q.pop_front());
            end
        end else begin
            checkOutput($sformatf("%s out_valid idle", tag), 64'(out_valid), 64'd0);
        end
        checkOutput($sformatf("%s in_ready", tag), 64'(in_ready), 64'(v.exp_in_ready));
        if (v.in_valid && v.exp_in_ready && !rst) begin
            e.rd   = {v.exp_rd1, v.exp_rd0};
            e.user = v.user;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (rst || v.flush) begin
            exp_q.delete();
        end
        checkOutput($sformatf("%s busy_mask", tag), 64'(busy_mask), 64'(v.exp_busy));
        if (v.chk_user_zero) begin
            checkOutput($sformatf("%s user_out cleared", tag), 64'(user_out), 64'd0);
        end
    endtask

    initial begin
        //             iv ra0 ra1 dst res wen wa0 wd0      wa1 wd1   user      ordy fl eir rd0     rd1    busy    uz
        vecs[0]  = mk(0, 0,  0,  0,  0,  1,  3,  'h11,    0,  0,    64'h0,    1,   0, 1,  0,      0,     'h0000, 0);
        vecs[1]  = mk(1, 3,  0,  0,  0,  0,  0,  0,       0,  0,    64'hA1,   1,   0, 1,  'h11,   0,     'h0000, 0);
        vecs[2]  = mk(1, 5,  3,  0,  0,  3,  5,  'hA,     5,  'hB,  64'hA2,   1,   0, 1,  'hB,    'h11,  'h0000, 0);
        vecs[3]  = mk(1, 5,  0,  0,  0,  1,  0,  'hDEAD,  0,  0,    64'hA3,   1,   0, 1,  'hB,    0,     'h0000, 0);
        vecs[4]  = mk(1, 1,  1,  2,  1,  0,  0,  0,       0,  0,    64'hA4,   1,   0, 1,  0,      0,     'h0004, 0);
        vecs[5]  = mk(1, 2,  3,  0,  0,  0,  0,  0,       0,  0,    64'hA5,   1,   0, 0,  0,      0,     'h0004, 0);
        vecs[6]  = mk(1, 2,  3,  0,  0,  0,  0,  0,       0,  0,    64'hA5,   1,   0, 0,  0,      0,     'h0004, 0);
        vecs[7]  = mk(1, 2,  3,  0,  0,  2,  0,  0,       2,  'h55, 64'hA5,   1,   0, 1,  'h55,   'h11,  'h0000, 0);
        vecs[8]  = mk(1, 2,  2,  6,  1,  1,  6,  'h66,    0,  0,    64'hA6,   1,   0, 1,  'h55,   'h55,  'h0040, 0);
        vecs[9]  = mk(1, 6,  7,  0,  0,  1,  9,  'h99,    0,  0,    64'hA7,   1,   0, 0,  0,      0,     'h0040, 0);
        vecs[10] = mk(1, 6,  7,  0,  0,  3,  6,  'h77,    6,  'h88, 64'hA7,   1,   0, 1,  'h88,   0,     'h0000, 0);
        vecs[11] = mk(1, 9,  3,  0,  0,  0,  0,  0,       0,  0,    64'hA8,   1,   0, 1,  'h99,   'h11,  'h0000, 0);
        vecs[12] = mk(1, 5,  6,  0,  0,  0,  0,  0,       0,  0,    64'hA9,   0,   0, 0,  0,      0,     'h0000, 0);
        vecs[13] = mk(1, 5,  6,  0,  0,  0,  0,  0,       0,  0,    64'hA9,   0,   0, 0,  0,      0,     'h0000, 0);
        vecs[14] = mk(1, 5,  6,  0,  0,  0,  0,  0,       0,  0,    64'hA9,   0,   0, 0,  0,      0,     'h0000, 0);
        vecs[15] = mk(1, 5,  6,  0,  0,  0,  0,  0,       0,  0,    64'hA9,   1,   0, 1,  'hB,    'h88,  'h0000, 0);
        vecs[16] = mk(1, 1,  1,  4,  1,  0,  0,  0,       0,  0,    64'hAA,   1,   0, 1,  0,      0,     'h0010, 0);
        vecs[17] = mk(1, 4,  8,  0,  0,  1,  8,  'h123,   0,  0,    64'hAB,   0,   1, 0,  0,      0,     'h0000, 1);
        vecs[18] = mk(1, 4,  8,  0,  0,  0,  0,  0,       0,  0,    64'hAC,   1,   0, 1,  0,      'h123, 'h0000, 0);
        vecs[19] = mk(0, 0,  0,  0,  0,  0,  0,  0,       0,  0,    64'h0,    1,   0, 1,  0,      0,     'h0000, 0);

        // Reset arrives while a reader of reserved r10 is stalled and r10 is being written.
        hand[0]  = mk(1, 3,  3,  10, 1,  0,  0,  0,       0,  0,    64'hB0,   1,   0, 1,  'h11,   'h11,  'h0400, 0);
        hand[1]  = mk(1, 10, 3,  11, 1,  1,  10, 'hAB,    0,  0,    64'hB1,   1,   0, 0,  0,      0,     'h0000, 0);
        hand[2]  = mk(1, 3,  10, 0,  0,  0,  0,  0,       0,  0,    64'hB2,   1,   0, 1,  0,      0,     'h0000, 0);
        hand[3]  = mk(1, 5,  6,  0,  0,  0,  0,  0,       0,  0,    64'hB3,   1,   0, 1,  0,      0,     'h0000, 0);
        hand[4]  = mk(1, 8,  2,  0,  0,  0,  0,  0,       0,  0,    64'hB4,   1,   0, 1,  0,      0,     'h0000, 0);
        hand[5]  = mk(0, 0,  0,  0,  0,  0,  0,  0,       0,  0,    64'h0,    1,   0, 1,  0,      0,     'h0000, 0);

        reset        = 1'b1;
        flush        = 1'b0;
        in_valid     = 1'b0;
        rd_addr      = '0;
        dest_addr    = '0;
        dest_reserve = 1'b0;
        wr_en        = '0;
        wr_addr      = '0;
        wr_data      = '0;
        user_in      = '0;
        out_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset busy_mask", 64'(busy_mask), 64'd0);
        checkOutput("reset rd_data", 64'(rd_data), 64'd0);
        checkOutput("reset user_out", 64'(user_out), 64'd0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        applyStimulus(hand[0], 1'b0, "stall_reserve");
        applyStimulus(hand[1], 1'b1, "stall_reset");
        checkOutput("midreset out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset rd_data", 64'(rd_data), 64'd0);
        checkOutput("midreset user_out", 64'(user_out), 64'd0);
        for (int i = 2; i < 6; i++) begin
            applyStimulus(hand[i], 1'b0, $sformatf("post_reset%0d", i));
        end

        checkOutput("queue drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/w0rm_core_regfile_mp.md
# w0rm_core_regfile_mp

Multi-ported, scoreboarded register file for the W0RM core. It sits between decode and the ALU, in the register-fetch stage. It generalises the core register file in three ways: parametrised read and write port counts, a hardwired-zero register option, and a per-register busy scoreboard that stalls issue on read-after-write hazards. Operand data and the user/control word are registered once and handed to the ALU under a valid/ready handshake.

## Interface
- DATA_WIDTH, 32: register width.
- NUM_REGISTERS, 16: register count; AW = log2(NUM_REGISTERS), minimum 1.
- NUM_READ, 2: read ports, range 1..4.
- NUM_WRITE, 2: write ports, range 1..4.
- USER_WIDTH, 64: width of the pass-through control word.
- ZERO_REG, 0: when 1, register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  kills the in-flight fetch and clears the scoreboard.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  the instruction is accepted this cycle when in_valid is also high.
- rd_addr  in  NUM_READ*AW  source addresses; port k occupies bits [k*AW +: AW].
- dest_addr  in  AW  destination register of the issuing instruction.
- dest_reserve  in  1  mark dest_addr busy on acceptance.
- wr_en  in  NUM_WRITE  writeback enables.
- wr_addr  in  NUM_WRITE*AW  writeback addresses.
- wr_data  in  NUM_WRITE*DATA_WIDTH  writeback data.
- out_valid  out  1  operands are valid for the ALU.
- out_ready  in  1  the ALU consumes the operands.
- rd_data  out  NUM_READ*DATA_WIDTH  registered operands.
- user_in  in  USER_WIDTH  control word from decode.
- user_out  out  USER_WIDTH  registered control word.
- busy_mask  out  NUM_REGISTERS  scoreboard state, for debug and forwarding.

## Operation
- Write resolution: all enabled wr ports update the array every cycle, regardless of stall or flush.
  - Same address on several ports: the highest port index wins.
  - With ZERO_REG=1, writes to register 0 are dropped.
- Effective read value: a source matching an enabled write this cycle takes that write's data (write-first bypass, highest port index wins). Otherwise it takes the array value. Register 0 with ZERO_REG=1 reads 0.
- Hazard: any source k whose busy bit is set and which is not satisfied by a bypass this cycle.
- in_ready = ~hazard & (~out_valid | out_ready) & ~flush.
- Accept (in_valid & in_ready):
  - capture the effective read values into rd_data;
  - capture user_in into user_out;
  - set out_valid.
- Consume (out_valid & out_ready, no accept in the same cycle): clear out_valid.
- Stall (out_valid & ~out_ready): rd_data and user_out hold.
- Scoreboard, per register, each cycle:
  - any enabled write to the register clears its bit;
  - acceptance with dest_reserve sets the bit for dest_addr;
  - set wins over clear on the same register in the same cycle.
- Flush:
  - out_valid goes to 0, user_out to 0, busy_mask to all-0;
  - rd_data holds;
  - array writes in the flush cycle still land.
- Reset, synchronous, next edge:
  - all registers 0, busy_mask 0, out_valid 0, rd_data 0, user_out 0;
  - in_ready is low while reset is asserted;
  - reset overrides flush and writes in the same cycle.

## Timing
- Accept-to-out_valid latency: 1 cycle. Throughput: one instruction per cycle when there are no hazards and out_ready is held high.
- A writeback at edge N unblocks a stalled reader combinationally within cycle N through the bypass. The reader is accepted at edge N+1 with the bypassed value.
- A busy bit set at edge N is visible to the instruction presented in cycle N+1. Back-to-back dependent instructions stall until writeback.
- in_ready is combinational from in_valid-independent terms, busy_mask, rd_addr, wr_* and out_ready. There is no path from in_valid to in_ready.
- All outputs except in_ready are registered.

## Structure
- Shared package w0rm_core_pkg holds:
  - the log2 function;
  - the REG_ADDR_BITS derivation;
  - the port-slicing helper constants.
- Sub-module w0rm_core_scoreboard holds the busy bits and their set/clear/flush logic. It is parametrised by NUM_REGISTERS, NUM_WRITE and ZERO_REG.
- The array, the bypass muxes and the output stage stay in the top module.

## Test plan
- Reset, then write r3=0x11 on port 0. Issue an instruction reading r3 and r0 with ZERO_REG=1 -> one cycle later out_valid=1, rd_data = {0x00000000, 0x00000011}.
- Same-cycle conflict: port0 writes r5=0xA and port1 writes r5=0xB, while r5 is read in the same cycle -> the operand is 0xB and the array holds 0xB.
- RAW stall: issue r2 with dest_reserve=1, then a reader of r2 -> in_ready=0 until the writeback r2=0x55. The reader is then accepted in that writeback cycle and sees 0x55, and busy_mask[2]=0.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and rd_data/user_out are stable. Raise out_ready -> the next instruction is captured on that edge.
- Flush with busy r4 and out_valid=1 -> the next cycle shows out_valid=0, user_out=0, busy_mask=0. A reader of r4 is then accepted immediately.
- Reset mid-stall, with a pending reservation and a write asserted -> all registers read 0, busy_mask=0, out_valid=0.
